operand_loader: RTL and testbench
=================================

# operand_loader

Streaming front end for `dotProduct`. It accepts one (A, B) element pair per handshake beat and packs `DIM` pairs into the wide `A` and `B` operand vectors that `dotProduct` consumes. It double-buffers: one vector is assembled while the previous one is held on the outputs. This lets the matrix-multiply datapath run with no bubbles when the consumer is always ready.

## Interface
- `DIM`, 10, elements per vector; must match the downstream `dotProduct` `DIM`.
- `A_DATA_WIDTH`, 16, width of one A element.
- `B_DATA_WIDTH`, 16, width of one B element.
- `Clock`  in  1  rising-edge clock for all state.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `InValid`  in  1  upstream element pair valid.
- `InReady`  out  1  loader can accept a beat.
- `InA`  in  `A_DATA_WIDTH`  A element.
- `InB`  in  `B_DATA_WIDTH`  B element.
- `InLast`  in  1  final element of the current vector.
- `A`  out  `A_DATA_WIDTH*DIM`  packed A vector to `dotProduct`.
- `B`  out  `B_DATA_WIDTH*DIM`  packed B vector to `dotProduct`.
- `OutValid`  out  1  `A`/`B` hold an unconsumed vector.
- `OutReady`  in  1  consumer takes the vector.
- `Error`  out  1  sticky flag: element index `DIM-1` accepted without `InLast`.

## Operation
- **Beat:** a beat is accepted when `InValid && InReady`. The element index `count` runs 0..`DIM-1`, is `$clog2(DIM)` bits wide, and resets to 0.
- **Packing:** element k is written to `fillA[k*A_DATA_WIDTH +: A_DATA_WIDTH]` and to the matching lane of `fillB`. Element 0 sits at the LSBs.
- **Completion beat:** an accepted beat with `InLast`, or with `count == DIM-1`.
  - Lanes above the completing index are zero.
  - `count` returns to 0 and the fill buffer clears.
- **Short vectors:** an early `InLast` zero-pads the vector. This is legal and does not set `Error`.
- **Missing `InLast`:** completing at `count == DIM-1` without `InLast` still emits the vector and sets `Error`. `Error` stays set until reset.
- **Output slot:** the slot is free when `!OutValid || OutReady`.
  - If the slot is free on the completion edge, the completed vector loads into the `A`/`B` output registers and `OutValid` is set.
  - Otherwise the vector is held in the fill buffer. `pending` is set and `InReady` is 0.
- **State machine:**
  - `FILL` (`InReady`=1): moves to `PENDING` on a completion beat while the slot is busy.
  - `PENDING` (`InReady`=0): moves back to `FILL` on the first cycle the slot is free. On that edge the held vector loads to the outputs.
- **Clearing `OutValid`:** `OutValid` clears on `OutReady` unless a new vector loads on the same edge.
- **Held outputs:** `A`/`B` keep their last value after consumption and change only when a vector loads.
- **Simultaneous events:** consuming the output and completing a vector on the same edge loads the new vector with no gap. `OutValid` stays 1.

## Timing
- **Reset values:** `A`=0, `B`=0, `OutValid`=0, `Error`=0, `InReady`=1 (state `FILL`). Internally, `count`=0, the fill buffer is 0 and `pending`=0.
- **Reset mid-operation:** `Reset_n` low at any time discards the partial vector and any pending or output vector immediately (asynchronous).
- **Latency:** a completion beat on edge N gives `OutValid`=1 and new `A`/`B` from edge N onward.
- **Sustained rate:** with `OutReady` held at 1, one vector every `DIM` accepted beats. `InReady` never drops.
- **Backpressure:**
  - `InReady` falls on the edge after the completion beat whose vector cannot move.
  - It rises on the edge where the pending vector transfers.
- **Input stability:** `InA`/`InB` need not be held stable when `InReady`=0.

## Structure
- **Shared package:** the `clog2` function, the default `DIM`/width constants, and the `FILL`/`PENDING` state encoding. These are shared with `dotProduct` and the result collector.
- **Sub-module:** one sub-module, `lane_packer` (parameters `DIM`, `WIDTH`; inputs write index, data, write enable, clear; outputs the packed register). It is instantiated once for A and once for B.
- **Loader body:** `operand_loader` itself holds the counter, the FSM, the output registers and `Error`.
- **Size target:** about 150–250 lines total.

## Test plan
All scenarios use `DIM`=10 and 16-bit elements.
- **Reset:** hold `Reset_n`=0, then release. Outputs are all 0, `InReady`=1 and `Error`=0.
- **Full vector:** with `OutReady`=1, send 10 beats with A=B=0x0008 and `InLast` on beat 10. `OutValid` rises on the 10th accept edge with A=B=160'h0008 repeated. Downstream `dotProduct` then yields 640.
- **Short vector:** send beats with A=1,2,3 and `InLast` on the third. A=160'h…0003_0002_0001 with the upper 7 lanes 0, and `Error` stays 0.
- **Backpressure:** hold `OutReady`=0 and send two full vectors.
  - The first vector stays stable on the outputs.
  - `InReady` drops after the second vector completes.
  - When `OutReady` pulses for one cycle, the second vector appears on the next edge and `InReady` returns to 1.
- **Missing `InLast`:** send 10 beats with `InLast`=0. The vector is emitted and `Error`=1, and `Error` remains 1 through later good vectors until reset.
- **Reset mid-fill:** send 5 beats, pulse `Reset_n` low, then send 10 new beats of 0x0001. The output vector is all-0x0001 lanes with no stale data.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Shared constants, state encoding and helpers for the
// operand_loader / dotProduct / result collector slice.
package operand_loader_pkg;

    localparam int DEF_DIM          = 10;
    localparam int DEF_A_DATA_WIDTH = 16;
    localparam int DEF_B_DATA_WIDTH = 16;

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/operand_loader_if.sv
// Element-in / vector-out handshake bundle of operand_loader.
// master = upstream/downstream environment, slave = loader.
interface operand_loader_if
    import operand_loader_pkg::*;
#(
    parameter int DIM          = DEF_DIM,
    parameter int A_DATA_WIDTH = DEF_A_DATA_WIDTH,
    parameter int B_DATA_WIDTH = DEF_B_DATA_WIDTH
);
    logic                          InValid;
    logic                          InReady;
    logic [A_DATA_WIDTH-1:0]       InA;
    logic [B_DATA_WIDTH-1:0]       InB;
    logic                          InLast;
    logic [A_DATA_WIDTH*DIM-1:0]   A;
    logic [B_DATA_WIDTH*DIM-1:0]   B;
    logic                          OutValid;
    logic                          OutReady;
    logic                          Error;

    modport master (
        output InValid, InA, InB, InLast, OutReady,
        input  InReady, A, B, OutValid, Error
    );

    modport slave (
        input  InValid, InA, InB, InLast, OutReady,
        output InReady, A, B, OutValid, Error
    );

endinterface

// File: rtl/operand_loader_lane_packer.sv
// Fill buffer for one operand: writes element lanes by index,
// exposes the register and a write-through view of it.
module lane_packer
    import operand_loader_pkg::*;
#(
    parameter  int DIM   = DEF_DIM,
    parameter  int WIDTH = DEF_A_DATA_WIDTH,
    localparam int IDX_W = (clog2(DIM) < 1) ? 1 : clog2(DIM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     i_idx,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_we,
    input  logic                 i_clr,
    output logic [DIM*WIDTH-1:0] o_packed,
    output logic [DIM*WIDTH-1:0] o_next
);

    logic [DIM*WIDTH-1:0] r_packed;
    logic [DIM*WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_packed;
        for (int k = 0; k < DIM; k++) begin
            if (i_we && i_idx == IDX_W'(k)) begin
                w_next[k*WIDTH +: WIDTH] = i_data;
            end
        end
    end

    // Clear wins over write: the completing element leaves via o_next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_packed <= '0;
        end else if (i_clr) begin
            r_packed <= '0;
        end else begin
            r_packed <= w_next;
        end
    end

    assign o_packed = r_packed;
    assign o_next   = w_next;

endmodule

// File: rtl/operand_loader.sv
// Packs DIM (A,B) element beats into double-buffered operand
// vectors for dotProduct; holds one vector while filling the next.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DIM          = DEF_DIM,
    parameter int A_DATA_WIDTH = DEF_A_DATA_WIDTH,
    parameter int B_DATA_WIDTH = DEF_B_DATA_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset_n,
    operand_loader_if.slave  bus
);

    localparam int CNT_W = (clog2(DIM) < 1) ? 1 : clog2(DIM);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIM - 1);

    state_t                      r_state;
    logic [CNT_W-1:0]            r_count;
    logic [A_DATA_WIDTH*DIM-1:0] r_a;
    logic [B_DATA_WIDTH*DIM-1:0] r_b;
    logic                        r_out_valid;
    logic                        r_in_ready;
    logic                        r_error;

    logic                        w_accept;
    logic                        w_done;
    logic                        w_free;
    logic                        w_load;
    logic [A_DATA_WIDTH*DIM-1:0] w_fill_a;
    logic [B_DATA_WIDTH*DIM-1:0] w_fill_b;
    logic [A_DATA_WIDTH*DIM-1:0] w_next_a;
    logic [B_DATA_WIDTH*DIM-1:0] w_next_b;

    assign w_accept = bus.InValid && r_in_ready;
    assign w_done   = w_accept && (bus.InLast || r_count == LAST_IDX);
    assign w_free   = !r_out_valid || bus.OutReady;
    assign w_load   = (r_state == PENDING) ? w_free : (w_done && w_free);

    lane_packer #(.DIM(DIM), .WIDTH(A_DATA_WIDTH)) u_pack_a (
        .clk      (Clock),
        .rst_n    (Reset_n),
        .i_idx    (r_count),
        .i_data   (bus.InA),
        .i_we     (w_accept),
        .i_clr    (w_load),
        .o_packed (w_fill_a),
        .o_next   (w_next_a)
    );

    lane_packer #(.DIM(DIM), .WIDTH(B_DATA_WIDTH)) u_pack_b (
        .clk      (Clock),
        .rst_n    (Reset_n),
        .i_idx    (r_count),
        .i_data   (bus.InB),
        .i_we     (w_accept),
        .i_clr    (w_load),
        .o_packed (w_fill_b),
        .o_next   (w_next_b)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= FILL;
            r_in_ready  <= 1'b1;
            r_count     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_out_valid <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_count <= w_done ? '0 : r_count + 1'b1;
            end
            if (w_done && !bus.InLast) begin
                r_error <= 1'b1;
            end
            // A held vector loads from the register; a fresh one
            // loads write-through so the last element lands this edge.
            if (w_load) begin
                r_a         <= (r_state == PENDING) ? w_fill_a : w_next_a;
                r_b         <= (r_state == PENDING) ? w_fill_b : w_next_b;
                r_out_valid <= 1'b1;
            end else if (bus.OutReady) begin
                r_out_valid <= 1'b0;
            end
            unique case (r_state)
                FILL: begin
                    if (w_done && !w_free) begin
                        r_state    <= PENDING;
                        r_in_ready <= 1'b0;
                    end
                end
                PENDING: begin
                    if (w_free) begin
                        r_state    <= FILL;
                        r_in_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.InReady  = r_in_ready;
    assign bus.A        = r_a;
    assign bus.B        = r_b;
    assign bus.OutValid = r_out_valid;
    assign bus.Error    = r_error;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: element-level reference model
// compared every cycle, plus literal checks of key vectors.
module tb_operand_loader;

    localparam int DIM = 10;
    localparam int AW  = 16;
    localparam int BW  = 16;
    localparam int VW  = AW * DIM;

    logic Clock;
    logic Reset_n;

    operand_loader_if #(.DIM(DIM), .A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW)) bus ();

    operand_loader #(.DIM(DIM), .A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: element arrays, not packed registers
    logic [AW-1:0] m_fa [DIM];
    logic [BW-1:0] m_fb [DIM];
    logic [AW-1:0] m_oa [DIM];
    logic [BW-1:0] m_ob [DIM];
    int m_cnt;
    bit m_ov;
    bit m_pend;
    bit m_err;

    function automatic logic [VW-1:0] pack(input logic [15:0] v [DIM]);
        logic [VW-1:0] r;
        r = '0;
        for (int k = 0; k < DIM; k++) r[k*16 +: 16] = v[k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DIM; k++) begin
            m_fa[k] = '0; m_fb[k] = '0; m_oa[k] = '0; m_ob[k] = '0;
        end
        m_cnt = 0; m_ov = 0; m_pend = 0; m_err = 0;
    endtask

    task automatic model_load();
        for (int k = 0; k < DIM; k++) begin
            m_oa[k] = m_fa[k]; m_ob[k] = m_fb[k];
            m_fa[k] = '0; m_fb[k] = '0;
        end
    endtask

    task automatic model_step();
        bit free;
        bit loaded;
        free   = !m_ov || bus.OutReady;
        loaded = 0;
        if (m_pend) begin
            if (free) begin
                model_load(); m_pend = 0; loaded = 1;
            end
        end else if (bus.InValid) begin
            m_fa[m_cnt] = bus.InA;
            m_fb[m_cnt] = bus.InB;
            if (bus.InLast || m_cnt == DIM - 1) begin
                if (!bus.InLast) m_err = 1;
                m_cnt = 0;
                if (free) begin
                    model_load(); loaded = 1;
                end else begin
                    m_pend = 1;
                end
            end else begin
                m_cnt++;
            end
        end
        if (loaded) m_ov = 1;
        else if (bus.OutReady) m_ov = 0;
    endtask

    task automatic check_all();
        chk("A",        bus.A,                pack(m_oa));
        chk("B",        bus.B,                pack(m_ob));
        chk("OutValid", VW'(bus.OutValid),    VW'(m_ov));
        chk("InReady",  VW'(bus.InReady),     VW'(!m_pend));
        chk("Error",    VW'(bus.Error),       VW'(m_err));
    endtask

    task automatic tick();
        model_step();
        @(posedge Clock);
        #1;
        check_all();
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b,
                        input logic last);
        bus.InValid = 1'b1;
        bus.InA     = a;
        bus.InB     = b;
        bus.InLast  = last;
        tick();
        bus.InValid = 1'b0;
        bus.InLast  = 1'b0;
        bus.InA     = 16'($urandom);
        bus.InB     = 16'($urandom);
    endtask

    task automatic idle();
        bus.InValid = 1'b0;
        tick();
    endtask

    logic [VW-1:0] e_a;
    logic [VW-1:0] e_b;
    int dot;

    initial begin
        Reset_n      = 1'b0;
        bus.InValid  = 1'b0;
        bus.InA      = '0;
        bus.InB      = '0;
        bus.InLast   = 1'b0;
        bus.OutReady = 1'b0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_all();
        chk("reset_inready", VW'(bus.InReady), VW'(1));
        Reset_n = 1'b1;

        // full vector of 0x0008
        bus.OutReady = 1'b1;
        for (int i = 0; i < DIM; i++) begin
            beat(16'h0008, 16'h0008, i == DIM - 1);
            if (i == DIM - 2) chk("full_pre_valid", VW'(bus.OutValid), VW'(0));
        end
        chk("full_A", bus.A, {10{16'h0008}});
        chk("full_valid", VW'(bus.OutValid), VW'(1));
        dot = 0;
        for (int k = 0; k < DIM; k++)
            dot += int'(bus.A[k*16 +: 16]) * int'(bus.B[k*16 +: 16]);
        chk("full_dot", VW'(dot), VW'(640));

        // short vector 1,2,3
        idle();
        beat(16'd1, 16'd1, 1'b0);
        beat(16'd2, 16'd2, 1'b0);
        beat(16'd3, 16'd3, 1'b1);
        chk("short_A", bus.A, VW'(48'h0003_0002_0001));
        chk("short_err", VW'(bus.Error), VW'(0));

        // backpressure: two vectors with consumer stalled
        idle();
        bus.OutReady = 1'b0;
        e_a = '0;
        e_b = '0;
        for (int i = 0; i < DIM; i++) begin
            beat(16'h0010 + 16'(i), 16'h0100 + 16'(i), i == DIM - 1);
            e_a[i*16 +: 16] = 16'h0010 + 16'(i);
        end
        for (int i = 0; i < DIM; i++) begin
            beat(16'h0020 + 16'(i), 16'h0200 + 16'(i), i == DIM - 1);
            e_b[i*16 +: 16] = 16'h0020 + 16'(i);
        end
        chk("bp_inready_low", VW'(bus.InReady), VW'(0));
        chk("bp_hold_v1", bus.A, e_a);
        repeat (3) idle();
        chk("bp_stable_v1", bus.A, e_a);
        bus.OutReady = 1'b1;
        tick();
        bus.OutReady = 1'b0;
        chk("bp_v2_loaded", bus.A, e_b);
        chk("bp_inready_high", VW'(bus.InReady), VW'(1));
        chk("bp_v2_valid", VW'(bus.OutValid), VW'(1));
        bus.OutReady = 1'b1;
        idle();

        // missing InLast sets sticky Error
        for (int i = 0; i < DIM; i++) beat(16'(i + 5), 16'd2, 1'b0);
        chk("miss_err", VW'(bus.Error), VW'(1));
        chk("miss_valid", VW'(bus.OutValid), VW'(1));
        beat(16'd7, 16'd7, 1'b0);
        beat(16'd9, 16'd9, 1'b1);
        chk("miss_err_sticky", VW'(bus.Error), VW'(1));

        // reset in the middle of a fill
        for (int i = 0; i < 5; i++) beat(16'hAAAA, 16'h5555, 1'b0);
        Reset_n = 1'b0;
        #2;
        model_reset();
        check_all();
        chk("rst_err_clear", VW'(bus.Error), VW'(0));
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        for (int i = 0; i < DIM; i++) beat(16'h0001, 16'h0001, i == DIM - 1);
        chk("rst_A", bus.A, {10{16'h0001}});
        chk("rst_B", bus.B, {10{16'h0001}});
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
